// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants, types and helpers for the audio flash reader.
//   KEY_PLAY / KEY_STOP  : moderated key codes that start / stop playback
//   ADDR_W               : flash word-address width
//   LAST_ADDR_DEFAULT    : default last valid flash word address
//   state_t              : reader FSM state encoding
//   sample_half()        : picks one 16-bit sample out of a 32-bit flash word
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam logic [7:0] KEY_PLAY = 8'h24;
  localparam logic [7:0] KEY_STOP = 8'h23;

  localparam int unsigned ADDR_W = 23;
  localparam logic [ADDR_W-1:0] LAST_ADDR_DEFAULT = 23'h7FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    SAMPLE_A  = 3'd3,
    SAMPLE_B  = 3'd4
  } state_t;

  // Forward playback emits [15:0] then [31:16]; backward emits the halves in
  // reverse so the audio plays mirrored. The upper half is the one wanted
  // exactly when the direction bit equals the "second half" bit.
  function automatic logic [15:0] sample_half(input logic [31:0] word,
                                              input logic        fwd,
                                              input logic        second);
    logic [15:0] half;
    if (fwd == second) begin
      half = word[31:16];
    end else begin
      half = word[15:0];
    end
    return half;
  endfunction

endpackage

// File: rtl/flash_addr_stepper.sv
// ---------------------------------------------------------------------------
// flash_addr_stepper
// Computes the next flash word address with wrap-around at both ends.
//   addr      in  current word address
//   forward   in  1 = step up, 0 = step down
//   last      in  last valid word address (wrap point)
//   next_addr out stepped address
// Forward : addr == last ? 0    : addr + 1
// Backward: addr == 0    ? last : addr - 1
// ---------------------------------------------------------------------------
module flash_addr_stepper
  import audio_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              forward,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] next_addr
);

  always_comb begin
    next_addr = addr;
    if (forward) begin
      if (addr == last) begin
        next_addr = '0;
      end else begin
        next_addr = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      if (addr == '0) begin
        next_addr = last;
      end else begin
        next_addr = addr - {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/audio_flash_reader.sv
// ---------------------------------------------------------------------------
// audio_flash_reader
// Streams 16-bit audio samples out of a 32-bit-wide Avalon-MM flash. Each
// flash word holds two samples; one word is fetched, its two halves are
// presented on consecutive sample ticks, then the address is stepped in the
// live playback direction and the next word is fetched.
//
// Ports
//   clk                 in   system clock
//   reset               in   synchronous, active-high reset
//   key_code[7:0]       in   8'h24 play, 8'h23 stop, others ignored
//   forward             in   playback direction (1 = forward)
//   sample_tick         in   one-cycle pulse at the audio sample rate
//   flash_read          out  Avalon-MM read request
//   flash_address[22:0] out  word address of the request
//   flash_waitrequest   in   slave stall
//   flash_readdata[31:0]in   returned word (two samples)
//   flash_readdatavalid in   readdata valid this cycle
//   audio_out[15:0]     out  current sample
//   audio_valid         out  one-cycle pulse when audio_out updates
//   playing             out  play/stop state
//   underrun            out  sticky: tick arrived with no sample ready
//
// State      | meaning
// -----------+----------------------------------------------------------
// IDLE       | stopped, no request outstanding
// FETCH      | flash_read held high until the slave accepts it
// WAIT_DATA  | request accepted, waiting for readdatavalid
// SAMPLE_A   | word buffered, first half goes out on next playing tick
// SAMPLE_B   | first half sent, second half goes out on next playing tick
// ---------------------------------------------------------------------------
module audio_flash_reader
  import audio_pkg::*;
#(
  parameter logic [22:0] LAST_ADDR = audio_pkg::LAST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_code,
  input  logic        forward,
  input  logic        sample_tick,
  output logic        flash_read,
  output logic [22:0] flash_address,
  input  logic        flash_waitrequest,
  input  logic [31:0] flash_readdata,
  input  logic        flash_readdatavalid,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output logic        playing,
  output logic        underrun
);

  state_t      state;
  logic        playing_next;
  logic        tick_live;
  logic [22:0] next_addr;

  // Buffered flash word and the direction captured with it. Deliberately
  // not reset: contents only matter after a fresh readdatavalid.
  logic [31:0] data_word;
  logic        data_fwd;

  // Ticks are qualified by the registered playing value, so a key arriving
  // in the same cycle as a tick only affects later ticks.
  assign tick_live = sample_tick && playing;

  always_comb begin
    playing_next = playing;
    if (key_code == KEY_PLAY) begin
      playing_next = 1'b1;
    end else if (key_code == KEY_STOP) begin
      playing_next = 1'b0;
    end
  end

  flash_addr_stepper u_stepper (
    .addr      (flash_address),
    .forward   (forward),
    .last      (LAST_ADDR),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset && (state == WAIT_DATA) && flash_readdatavalid) begin
      data_word <= flash_readdata;
      data_fwd  <= forward;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      flash_read    <= 1'b0;
      flash_address <= '0;
      audio_out     <= '0;
      audio_valid   <= 1'b0;
      playing       <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      playing     <= playing_next;

      case (state)
        IDLE: begin
          if (tick_live) begin
            underrun <= 1'b1;
          end
          if (playing) begin
            state      <= FETCH;
            flash_read <= 1'b1;
          end
        end

        // A stop key never abandons the request; the handshake always
        // completes and the word is drained through the sample states.
        FETCH: begin
          if (tick_live) begin
            underrun <= 1'b1;
          end
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state      <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (tick_live) begin
            underrun <= 1'b1;
          end
          if (flash_readdatavalid) begin
            state <= SAMPLE_A;
          end
        end

        SAMPLE_A: begin
          if (tick_live) begin
            audio_out   <= sample_half(data_word, data_fwd, 1'b0);
            audio_valid <= 1'b1;
            state       <= SAMPLE_B;
          end
        end

        // Address steps with the live direction, not the latched one, so a
        // direction change takes effect on the very next fetch.
        SAMPLE_B: begin
          if (tick_live) begin
            audio_out     <= sample_half(data_word, data_fwd, 1'b1);
            audio_valid   <= 1'b1;
            flash_address <= next_addr;
            if (playing_next) begin
              state      <= FETCH;
              flash_read <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state      <= IDLE;
          flash_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_audio_flash_reader
// Directed bench for audio_flash_reader: play/stop control, forward and
// backward sample ordering, address wrap at both ends, wait-state handling,
// underrun detection and reset during an outstanding request.
// ---------------------------------------------------------------------------
module tb_audio_flash_reader;
  import audio_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  key_code;
  logic        forward;
  logic        sample_tick;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        playing;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  audio_flash_reader #(.LAST_ADDR(23'h7FFFF)) dut (
    .clk                 (clk),
    .reset               (reset),
    .key_code            (key_code),
    .forward             (forward),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_out           (audio_out),
    .audio_valid         (audio_valid),
    .playing             (playing),
    .underrun            (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample tick; checks the output the cycle after the tick.
  task automatic do_tick(input string tag, input logic exp_valid, input logic [15:0] exp_out);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk({tag, "_valid"}, {31'd0, audio_valid}, {31'd0, exp_valid});
    chk({tag, "_out"}, {16'd0, audio_out}, {16'd0, exp_out});
  endtask

  // Slave side of one read: waits (bounded) for the request, checks the
  // address, stalls for 'waits' cycles, accepts, then returns 'word'.
  task automatic serve_read(input string tag, input logic [22:0] exp_addr,
                            input logic [31:0] word, input int waits,
                            input bit tick_in_wait);
    for (int i = 0; i < 20 && flash_read !== 1'b1; i++) step();
    chk({tag, "_req"}, {31'd0, flash_read}, 32'd1);
    chk({tag, "_addr"}, {9'd0, flash_address}, {9'd0, exp_addr});
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_hold_rd"}, {31'd0, flash_read}, 32'd1);
      chk({tag, "_hold_addr"}, {9'd0, flash_address}, {9'd0, exp_addr});
    end
    flash_waitrequest = 1'b0;
    step();
    flash_waitrequest = 1'b1;
    chk({tag, "_rd_drop"}, {31'd0, flash_read}, 32'd0);
    if (tick_in_wait) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk({tag, "_underrun"}, {31'd0, underrun}, 32'd1);
      chk({tag, "_no_valid"}, {31'd0, audio_valid}, 32'd0);
    end
    flash_readdata      = word;
    flash_readdatavalid = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    flash_readdata      = 32'hDEAD_BEEF;
    chk({tag, "_single"}, {31'd0, flash_read}, 32'd0);
  endtask

  initial begin
    reset               = 1'b1;
    key_code            = 8'h00;
    forward             = 1'b1;
    sample_tick         = 1'b0;
    flash_waitrequest   = 1'b1;
    flash_readdata      = 32'h0;
    flash_readdatavalid = 1'b0;

    // Reset values
    step(); step(); step();
    chk("rst_read", {31'd0, flash_read}, 32'd0);
    chk("rst_addr", {9'd0, flash_address}, 32'd0);
    chk("rst_out", {16'd0, audio_out}, 32'd0);
    chk("rst_valid", {31'd0, audio_valid}, 32'd0);
    chk("rst_playing", {31'd0, playing}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    step();

    // Tick while stopped in IDLE: no underrun
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("idle_tick_no_underrun", {31'd0, underrun}, 32'd0);

    // Forward play from address 0
    forward  = 1'b1;
    key_code = KEY_PLAY;
    step();
    key_code = 8'h00;
    chk("play_set", {31'd0, playing}, 32'd1);
    key_code = 8'h55;
    step();
    key_code = 8'h00;
    chk("play_held_other_key", {31'd0, playing}, 32'd1);
    serve_read("fwd0", 23'h0, 32'hBBBB_AAAA, 0, 1'b0);
    do_tick("fwd0_t1", 1'b1, 16'hAAAA);
    step();
    chk("valid_one_cycle", {31'd0, audio_valid}, 32'd0);
    do_tick("fwd0_t2", 1'b1, 16'hBBBB);
    chk("fwd0_next_rd", {31'd0, flash_read}, 32'd1);
    chk("fwd0_next_addr", {9'd0, flash_address}, 32'd1);

    // Backward at address 0, wrap to LAST_ADDR
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    key_code = KEY_PLAY;
    step();
    key_code = 8'h00;
    forward  = 1'b0;
    serve_read("bwd0", 23'h0, 32'h2222_1111, 0, 1'b0);
    do_tick("bwd0_t1", 1'b1, 16'h2222);
    do_tick("bwd0_t2", 1'b1, 16'h1111);

    // Forward at LAST_ADDR wraps to 0
    forward = 1'b1;
    serve_read("last", 23'h7FFFF, 32'h4444_3333, 0, 1'b0);
    do_tick("last_t1", 1'b1, 16'h3333);
    do_tick("last_t2", 1'b1, 16'h4444);

    // Stop in SAMPLE_B, ticks ignored, resume
    serve_read("stop", 23'h0, 32'h6666_5555, 0, 1'b0);
    do_tick("stop_t1", 1'b1, 16'h5555);
    key_code = KEY_STOP;
    step();
    key_code = 8'h00;
    chk("stop_clr", {31'd0, playing}, 32'd0);
    do_tick("stopped_t1", 1'b0, 16'h5555);
    do_tick("stopped_t2", 1'b0, 16'h5555);
    do_tick("stopped_t3", 1'b0, 16'h5555);
    // Play key and tick together: tick judged against old playing=0
    key_code    = KEY_PLAY;
    sample_tick = 1'b1;
    step();
    key_code    = 8'h00;
    sample_tick = 1'b0;
    chk("same_cycle_valid", {31'd0, audio_valid}, 32'd0);
    chk("same_cycle_playing", {31'd0, playing}, 32'd1);
    do_tick("resume_t", 1'b1, 16'h6666);
    chk("resume_rd", {31'd0, flash_read}, 32'd1);
    chk("resume_addr", {9'd0, flash_address}, 32'd1);
    chk("pre_underrun", {31'd0, underrun}, 32'd0);

    // Five wait states, tick during WAIT_DATA raises underrun
    serve_read("wait5", 23'h1, 32'h8888_7777, 5, 1'b1);
    do_tick("wait5_t1", 1'b1, 16'h7777);
    do_tick("wait5_t2", 1'b1, 16'h8888);
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Reset during FETCH (slave stalled, request outstanding)
    chk("fetch_pending", {31'd0, flash_read}, 32'd1);
    chk("fetch_addr", {9'd0, flash_address}, 32'd2);
    reset = 1'b1;
    step();
    chk("mid_rst_read", {31'd0, flash_read}, 32'd0);
    chk("mid_rst_addr", {9'd0, flash_address}, 32'd0);
    chk("mid_rst_playing", {31'd0, playing}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("mid_rst_state", {29'd0, dut.state}, {29'd0, IDLE});
    reset = 1'b0;
    step();
    chk("post_rst_idle", {31'd0, flash_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_flash_reader.md
AUDIO_FLASH_READER -- requirements
Module: audio_flash_reader

Interface
REQ-001 SHALL have parameter: LAST_ADDR, default 23'h7FFFF, last valid flash word address.
REQ-002 SHALL have port: clk  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: key_code  input  8  moderated key code; 8'h24 = play, 8'h23 = stop, all other values ignored.
REQ-005 SHALL have port: forward  input  1  playback direction; 1 = forward, 0 = backward.
REQ-006 SHALL have port: sample_tick  input  1  one-cycle pulse at the audio sample rate.
REQ-007 SHALL have port: flash_read  output  1  Avalon-MM read request.
REQ-008 SHALL have port: flash_address  output  23  word address of the request.
REQ-009 SHALL have port: flash_waitrequest  input  1  slave stall; request is accepted in a cycle where flash_read=1 and flash_waitrequest=0.
REQ-010 SHALL have port: flash_readdata  input  32  returned word, holding two 16-bit samples.
REQ-011 SHALL have port: flash_readdatavalid  input  1  flash_readdata is valid this cycle.
REQ-012 SHALL have port: audio_out  output  16  current sample.
REQ-013 SHALL have port: audio_valid  output  1  one-cycle pulse when audio_out is updated.
REQ-014 SHALL have port: playing  output  1  play/stop state.
REQ-015 SHALL have port: underrun  output  1  sticky flag: a tick arrived while no sample was available.

Function
REQ-016 SHALL set playing on key_code==8'h24 and clear it on key_code==8'h23; playing SHALL be held for all other codes.
REQ-017 SHALL implement states IDLE, FETCH, WAIT_DATA, SAMPLE_A and SAMPLE_B.
REQ-018 IDLE: SHALL move to FETCH in the cycle after playing is 1.
REQ-019 FETCH: SHALL hold flash_read=1 and flash_address stable until accepted, then deassert flash_read next cycle and enter WAIT_DATA.
REQ-020 FETCH: SHALL complete the handshake even if stop occurs, and SHALL never abandon a request.
REQ-021 WAIT_DATA: on flash_readdatavalid, SHALL latch flash_readdata and the forward value, then enter SAMPLE_A.
REQ-022 Sample order SHALL be forward: [15:0] then [31:16]; backward: [31:16] then [15:0]; the order SHALL use the direction latched in WAIT_DATA.
REQ-023 SAMPLE_A: on sample_tick with playing=1, SHALL load the first half into audio_out and go to SAMPLE_B.
REQ-024 SAMPLE_B: on sample_tick with playing=1, SHALL load the second half, step the address, and go to FETCH.
REQ-025 After a step, SHALL go to IDLE instead of FETCH if playing=0.
REQ-026 A sample_tick in SAMPLE_A/SAMPLE_B with playing=0 SHALL be ignored; the state SHALL be held, and audio_out and audio_valid SHALL be unchanged.
REQ-027 Latency: audio_out and audio_valid=1 SHALL appear the cycle after the accepting tick; audio_valid SHALL be 0 otherwise.
REQ-028 Address step SHALL use the live forward input: forward gives addr==LAST_ADDR ? 0 : addr+1; backward gives addr==0 ? LAST_ADDR : addr-1.
REQ-029 A sample_tick in IDLE/FETCH/WAIT_DATA with playing=1 SHALL set underrun, with no other effect.
REQ-030 When key_code and sample_tick arrive in the same cycle, the tick SHALL be judged against the pre-update playing value.

Reset
REQ-031 On reset, SHALL set state IDLE, flash_read=0, flash_address=0, audio_out=0, audio_valid=0, playing=0 and underrun=0.
REQ-032 Reset SHALL take priority over all inputs, including mid-handshake; the bench SHALL keep the slave idle for one cycle after reset.
REQ-033 The latched data word SHALL NOT be reset.

Structure
REQ-034 Package audio_pkg SHALL hold KEY_PLAY=8'h24, KEY_STOP=8'h23, the state enum and the LAST_ADDR default.
REQ-035 A sub-module flash_addr_stepper (addr, forward, last -> next_addr) SHALL implement the wrap rules of REQ-028.

Verification
REQ-036 Reset, then key 8'h24, forward=1, slave returns 32'hBBBB_AAAA for addr 0 -> read at addr 0; ticks give audio_out 16'hAAAA then 16'hBBBB; next read at addr 1.
REQ-037 forward=0 at addr 0, word 32'h2222_1111 -> audio_out 16'h2222 then 16'h1111; next read at addr 23'h7FFFF.
REQ-038 Forward at addr LAST_ADDR, two ticks -> next flash_address 0.
REQ-039 Key 8'h23 in SAMPLE_B, three ticks -> no audio_valid; key 8'h24 then one tick -> second half out, read at next addr.
REQ-040 flash_waitrequest held 5 cycles -> flash_read and flash_address stable for 6 cycles, single request issued; a tick during WAIT_DATA -> underrun=1.
REQ-041 Reset asserted during FETCH -> next cycle flash_read=0, address 0, playing=0, state IDLE.
